// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// one outstanding transaction at a time, with a WAIT-state timeout that aborts with zero data.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [15:0] LP_LIMIT = 16'(TIMEOUT - 32'd1);
  localparam logic        OWN_IFU  = 1'b0;
  localparam logic        OWN_LSU  = 1'b1;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_grant;
  logic        r_owner;
  logic        r_abort;
  logic [15:0] r_cnt;
  logic [31:0] r_addr;
  logic        r_wen;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic [31:0] r_ifu_rdata;
  logic [31:0] r_lsu_rdata;
  logic        w_grant_ifu;
  logic        w_grant_lsu;
  logic        w_cnt_hit;

  assign w_cnt_hit = (r_cnt == LP_LIMIT);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Arbitration and next-state decode
  always_comb begin
    w_next_state = r_state;
    w_grant_ifu  = 1'b0;
    w_grant_lsu  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ifu_req_valid && lsu_req_valid) begin
          if (r_last_grant == OWN_IFU) begin
            w_grant_lsu = 1'b1;
          end else begin
            w_grant_ifu = 1'b1;
          end
        end else if (lsu_req_valid) begin
          w_grant_lsu = 1'b1;
        end else if (ifu_req_valid) begin
          w_grant_ifu = 1'b1;
        end else begin
          w_grant_ifu = 1'b0;
          w_grant_lsu = 1'b0;
        end
        if (w_grant_ifu || w_grant_lsu) begin
          w_next_state = S_REQ;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_REQ;
        end
      end
      S_WAIT: begin
        // A response arriving on the last counted cycle wins over the abort
        if (mem_resp_valid || w_cnt_hit) begin
          w_next_state = S_RESP;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_RESP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Request latch, WAIT counter and response capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= OWN_IFU;
      r_owner      <= OWN_IFU;
      r_abort      <= 1'b0;
      r_cnt        <= 16'd0;
      r_addr       <= 32'd0;
      r_wen        <= 1'b0;
      r_wdata      <= 32'd0;
      r_wmask      <= 4'd0;
      r_ifu_rdata  <= 32'd0;
      r_lsu_rdata  <= 32'd0;
    end else begin
      if (w_grant_ifu) begin
        r_owner      <= OWN_IFU;
        r_last_grant <= OWN_IFU;
        r_addr       <= ifu_addr;
        r_wen        <= 1'b0;
        r_wdata      <= 32'd0;
        r_wmask      <= 4'd0;
      end else if (w_grant_lsu) begin
        r_owner      <= OWN_LSU;
        r_last_grant <= OWN_LSU;
        r_addr       <= lsu_addr;
        r_wen        <= lsu_wen;
        r_wdata      <= lsu_wdata;
        r_wmask      <= lsu_wmask;
      end
      if (r_state == S_REQ && mem_req_ready) begin
        r_cnt <= 16'd0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (r_state == S_WAIT) begin
        if (mem_resp_valid) begin
          r_abort <= 1'b0;
          if (r_owner == OWN_LSU) begin
            r_lsu_rdata <= mem_rdata;
          end else begin
            r_ifu_rdata <= mem_rdata;
          end
        end else if (w_cnt_hit) begin
          r_abort <= 1'b1;
          if (r_owner == OWN_LSU) begin
            r_lsu_rdata <= 32'd0;
          end else begin
            r_ifu_rdata <= 32'd0;
          end
        end
      end
    end
  end

  // Readies are the only combinational outputs; they are held low while reset is asserted
  assign ifu_req_ready  = w_grant_ifu & ~reset;
  assign lsu_req_ready  = w_grant_lsu & ~reset;

  assign mem_req_valid  = (r_state == S_REQ);
  assign mem_addr       = r_addr;
  assign mem_wen        = r_wen;
  assign mem_wdata      = r_wdata;
  assign mem_wmask      = r_wmask;

  assign ifu_resp_valid = (r_state == S_RESP) && (r_owner == OWN_IFU);
  assign lsu_resp_valid = (r_state == S_RESP) && (r_owner == OWN_LSU);
  assign timeout_err    = (r_state == S_RESP) && r_abort;
  assign ifu_rdata      = r_ifu_rdata;
  assign lsu_rdata      = r_lsu_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected responses are queued at grant time
// and popped when the owner's response strobe is sampled.
module tb_mem_port_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        timeout_err;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
    logic        chk_rd;
    logic        tout;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic owner, input logic [31:0] rd, input logic chk_rd, input logic tout);
    exp_t e;
    e.owner  = owner;
    e.rdata  = rd;
    e.chk_rd = chk_rd;
    e.tout   = tout;
    sb.push_back(e);
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_ifu_ready"}, ifu_req_ready, 32'd0);
    chk({tag, "_lsu_ready"}, lsu_req_ready, 32'd0);
    chk({tag, "_ifu_resp"}, ifu_resp_valid, 32'd0);
    chk({tag, "_lsu_resp"}, lsu_resp_valid, 32'd0);
    chk({tag, "_ifu_rdata"}, ifu_rdata, 32'd0);
    chk({tag, "_lsu_rdata"}, lsu_rdata, 32'd0);
    chk({tag, "_mem_valid"}, mem_req_valid, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wen"}, mem_wen, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_wmask"}, mem_wmask, 32'd0);
    chk({tag, "_timeout"}, timeout_err, 32'd0);
  endtask

  // Called at an IDLE negedge; returns at the following negedge (DUT in REQ).
  task automatic grant(input logic iv, input logic lv, input logic exp_lsu);
    ifu_req_valid = iv;
    lsu_req_valid = lv;
    #1;
    chk("ifu_ready", ifu_req_ready, {31'd0, ~exp_lsu});
    chk("lsu_ready", lsu_req_ready, {31'd0, exp_lsu});
    @(negedge clk);
    chk("ready_off_in_req", ifu_req_ready | lsu_req_ready, 32'd0);
  endtask

  // Called in REQ; stalls, acks, waits, responds; returns at the RESP negedge.
  task automatic mem_serve(input int ready_wait, input int resp_wait, input logic [31:0] rd,
                           input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [3:0] wm);
    for (int i = 0; i <= ready_wait; i++) begin
      chk("mem_req_valid", mem_req_valid, 32'd1);
      chk("mem_addr", mem_addr, a);
      chk("mem_wen", mem_wen, {31'd0, w});
      chk("mem_wdata", mem_wdata, wd);
      chk("mem_wmask", mem_wmask, {28'd0, wm});
      if (i < ready_wait) begin
        mem_req_ready = 1'b0;
        @(negedge clk);
      end
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("mem_valid_in_wait", mem_req_valid, 32'd0);
    for (int i = 0; i < resp_wait; i++) begin
      @(negedge clk);
      chk("no_strobe_in_wait", ifu_resp_valid | lsu_resp_valid, 32'd0);
    end
    mem_resp_valid = 1'b1;
    mem_rdata      = rd;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'd0;
  endtask

  task automatic check_resp();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL resp_unexpected: observed ifu %b lsu %b expected empty scoreboard",
             ifu_resp_valid, lsu_resp_valid);
    end else begin
      e = sb.pop_front();
      chk("ifu_resp_valid", ifu_resp_valid, {31'd0, ~e.owner});
      chk("lsu_resp_valid", lsu_resp_valid, {31'd0, e.owner});
      chk("timeout_err", timeout_err, {31'd0, e.tout});
      if (e.chk_rd) begin
        chk("resp_rdata", e.owner ? lsu_rdata : ifu_rdata, e.rdata);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_0040;
    lsu_req_valid = 1'b0; lsu_addr = 32'd0; lsu_wen = 1'b0; lsu_wdata = 32'd0; lsu_wmask = 4'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    outputs_zero("reset");
    ifu_req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // IFU alone, minimum latency
    ifu_addr = 32'h8000_0000;
    push(1'b0, 32'h0000_0297, 1'b1, 1'b0);
    grant(1'b1, 1'b0, 1'b0);
    ifu_req_valid = 1'b0;
    mem_serve(0, 0, 32'h0000_0297, 32'h8000_0000, 1'b0, 32'd0, 4'd0);
    check_resp();
    @(negedge clk);
    chk("ifu_strobe_one_cycle", ifu_resp_valid, 32'd0);
    chk("ifu_rdata_hold", ifu_rdata, 32'h0000_0297);

    // Response strobe while IDLE is ignored
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_rdata = 32'd0;
    chk("idle_resp_ignored", ifu_resp_valid | lsu_resp_valid | mem_req_valid, 32'd0);
    chk("idle_rdata_hold", ifu_rdata, 32'h0000_0297);

    // Round-robin alternation out of reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_rdata_clear", ifu_rdata, 32'd0);
    lsu_addr = 32'h0000_0100; ifu_addr = 32'h0000_0200;
    lsu_wdata = 32'hFFFF_FFFF; lsu_wmask = 4'hF;
    for (int k = 0; k < 4; k++) begin
      logic el;
      el = (k % 2 == 0);
      push(el, 32'hA000_0000 + 32'(k), 1'b1, 1'b0);
      grant(1'b1, 1'b1, el);
      if (el) begin
        mem_serve(0, 0, 32'hA000_0000 + 32'(k), 32'h0000_0100, 1'b0, 32'hFFFF_FFFF, 4'hF);
      end else begin
        mem_serve(0, 0, 32'hA000_0000 + 32'(k), 32'h0000_0200, 1'b0, 32'd0, 4'd0);
      end
      check_resp();
      @(negedge clk);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    @(negedge clk);

    // LSU store with a stalled memory port; inputs change after grant
    lsu_addr = 32'h8000_1000; lsu_wen = 1'b1; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'b0011;
    push(1'b1, 32'd0, 1'b0, 1'b0);
    grant(1'b0, 1'b1, 1'b1);
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_wdata = 32'd0; lsu_wmask = 4'd0; lsu_addr = 32'd0;
    mem_serve(5, 1, 32'hDEAD_BEEF, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'b0011);
    check_resp();
    @(negedge clk);

    // Timeout abort: strobe, zero data and timeout_err four WAIT cycles after entry
    ifu_addr = 32'h0000_0300;
    push(1'b0, 32'd0, 1'b1, 1'b1);
    grant(1'b1, 1'b0, 1'b0);
    ifu_req_valid = 1'b0;
    chk("to_mem_valid", mem_req_valid, 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("to_no_early_strobe", ifu_resp_valid | timeout_err, 32'd0);
    end
    @(negedge clk);
    check_resp();
    @(negedge clk);
    chk("to_err_one_cycle", timeout_err, 32'd0);

    // Next grant proceeds; response on the last counted cycle is a normal response
    lsu_addr = 32'h0000_0500;
    push(1'b1, 32'h5555_AAAA, 1'b1, 1'b0);
    grant(1'b0, 1'b1, 1'b1);
    lsu_req_valid = 1'b0;
    mem_serve(0, TO - 1, 32'h5555_AAAA, 32'h0000_0500, 1'b0, 32'd0, 4'd0);
    check_resp();
    @(negedge clk);

    // Reset during WAIT drops the transaction; late response ignored
    ifu_addr = 32'h0000_0400;
    grant(1'b1, 1'b0, 1'b0);
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    outputs_zero("rst_wait");
    @(negedge clk);
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0BAD;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_rdata = 32'd0;
    outputs_zero("late_resp");
    @(negedge clk);
    outputs_zero("late_resp2");

    ifu_addr = 32'h8000_0004;
    push(1'b0, 32'h0000_0013, 1'b1, 1'b0);
    grant(1'b1, 1'b0, 1'b0);
    ifu_req_valid = 1'b0;
    mem_serve(1, 2, 32'h0000_0013, 32'h8000_0004, 1'b0, 32'd0, 4'd0);
    check_resp();
    @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, 256: WAIT-state cycles without a memory response before abort; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port ifu_req_valid, input, 1: instruction-fetch read request.
REQ-005 SHALL have port ifu_req_ready, output, 1: IFU request accepted this cycle.
REQ-006 SHALL have port ifu_addr, input, 32: fetch address.
REQ-007 SHALL have port ifu_resp_valid, output, 1: one-cycle IFU response strobe.
REQ-008 SHALL have port ifu_rdata, output, 32: fetched word.
REQ-009 SHALL have port lsu_req_valid, input, 1: load/store request.
REQ-010 SHALL have port lsu_req_ready, output, 1: LSU request accepted this cycle.
REQ-011 SHALL have ports lsu_addr (input, 32), lsu_wen (input, 1), lsu_wdata (input, 32) and lsu_wmask (input, 4): LSU address, write flag, write data and byte mask.
REQ-012 SHALL have ports lsu_resp_valid (output, 1) and lsu_rdata (output, 32): one-cycle LSU response strobe and load data.
REQ-013 SHALL have ports mem_req_valid (output, 1) and mem_req_ready (input, 1): request handshake toward the shared memory port.
REQ-014 SHALL have ports mem_addr (output, 32), mem_wen (output, 1), mem_wdata (output, 32) and mem_wmask (output, 4): the forwarded request fields.
REQ-015 SHALL have ports mem_resp_valid (input, 1) and mem_rdata (input, 32): memory response strobe and read data.
REQ-016 SHALL have port timeout_err, output, 1: one-cycle pulse, coincident with the response strobe of an aborted transaction.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT and RESP, with exactly one outstanding transaction at a time.
REQ-018 In IDLE, SHALL assert ready combinationally to exactly one valid requester; no other state asserts either ready.
REQ-019 SHALL arbitrate round-robin: when both requesters are valid, grant the one not granted last; register last_grant resets to IFU, so LSU wins the first tie.
REQ-020 On grant, SHALL latch owner, address, wen, wdata and wmask (IFU: wen=0, wdata=0, wmask=0), and go to REQ.
REQ-021 In REQ, SHALL hold mem_req_valid=1 with the latched fields stable until mem_req_ready=1, then go to WAIT.
REQ-022 In WAIT, SHALL increment a 16-bit counter, cleared on entry to WAIT.
REQ-023 In WAIT, when mem_resp_valid=1, SHALL capture mem_rdata and go to RESP.
REQ-024 In WAIT, when the counter reaches TIMEOUT-1 with mem_resp_valid=0, SHALL capture rdata as 0, set the abort flag and go to RESP.
REQ-025 If mem_resp_valid=1 in the same cycle the counter reaches TIMEOUT-1, SHALL treat it as a normal response, not an abort.
REQ-026 In RESP, SHALL assert the owner's resp_valid for exactly one cycle with the captured rdata, pulse timeout_err if aborted, and return to IDLE.
REQ-027 mem_req_valid, ifu_resp_valid, lsu_resp_valid and timeout_err SHALL be registered-state decodes, free of glitches from requester inputs.
REQ-028 Stores SHALL also wait for mem_resp_valid as the write acknowledge; lsu_rdata on a store response is don't-care.
REQ-029 SHALL ignore mem_resp_valid in IDLE, REQ and RESP; no state change and no strobe.
REQ-030 The non-owner's resp_valid SHALL remain 0, and ifu_rdata/lsu_rdata SHALL hold their last captured value between strobes.
REQ-031 Minimum accept-to-response latency SHALL be 3 cycles: accept at n, mem_req_valid at n+1, mem_resp_valid at n+2, resp_valid at n+3.
REQ-032 Dropping a requester's valid while it is not yet granted SHALL be legal, with no side effect.

Reset
REQ-033 Asserting reset SHALL immediately force IDLE, last_grant=IFU, counter=0, abort flag=0 and captured rdata=0.
REQ-034 Reset SHALL drive all outputs to 0: both readies, both resp_valids, both rdatas, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask and timeout_err.
REQ-035 Reset mid-transaction SHALL drop the transaction with no response delivered; a late mem_resp_valid after deassertion is ignored per REQ-029.

Verification
REQ-036 IFU alone: addr 0x80000000 at cycle 0, mem_req_ready=1 at cycle 1, mem_resp_valid=1 with rdata 0x00000297 at cycle 2 -> ifu_resp_valid=1 and ifu_rdata=0x00000297 at cycle 3 only; lsu_resp_valid stays 0.
REQ-037 Both valid out of reset -> LSU granted first; both held valid -> grants alternate LSU, IFU, LSU, IFU across four transactions.
REQ-038 LSU store: addr 0x80001000, wdata 0x12345678, wmask 4'b0011, mem_req_ready held 0 for 5 cycles -> mem fields stable and mem_req_valid=1 throughout; lsu_resp_valid follows the ack.
REQ-039 TIMEOUT=4, no mem_resp_valid -> owner resp_valid=1, rdata=0 and timeout_err=1 in the same cycle, 4 WAIT cycles after entry; next grant then proceeds normally.
REQ-040 reset pulsed in WAIT, then mem_resp_valid=1 -> no resp_valid, state IDLE, all outputs 0; a subsequent IFU request completes normally.
